// File: rtl/tlut_sweep_cnt.sv
// Sweep counter for the temporal-LUT multiplier: programmable-modulus phase
// counter with Gray-coded phase, saturating epoch count and one-shot halt.
module tlut_sweep_cnt #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned EPOCH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               oneshot,
  input  logic [WIDTH-1:0]   mod_max,
  output logic [WIDTH-1:0]   cnt_out,
  output logic [WIDTH-1:0]   gray_out,
  output logic               rollover,
  output logic [EPOCH_W-1:0] epoch,
  output logic               epoch_sat,
  output logic               done
);

  localparam logic [EPOCH_W-1:0] EPOCH_MAX = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   cnt_d;
  logic [EPOCH_W-1:0] epoch_q;
  logic [EPOCH_W-1:0] epoch_d;
  logic               epoch_sat_q;
  logic               done_q;
  logic               term;
  logic               roll;

  // Terminal test uses >= so a lowered modulus wraps on the next enabled cycle.
  assign term = (cnt_q >= mod_max);
  assign roll = enable & term & ~clear & (state_q == ST_RUN);

  // Next phase: clear wins, then wrap, then increment; HALT holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (roll) begin
        cnt_d = '0;
      end else if (enable) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // Next epoch: counts completed sweeps, sticks at all-ones.
  always_comb begin
    epoch_d = epoch_q;
    if (clear) begin
      epoch_d = '0;
    end else if (roll && (epoch_q != EPOCH_MAX)) begin
      epoch_d = epoch_q + EPOCH_W'(1);
    end
  end

  // State, phase, epoch and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      epoch_q     <= '0;
      epoch_sat_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      epoch_q     <= epoch_d;
      epoch_sat_q <= (epoch_d == EPOCH_MAX);
      case (state_q)
        ST_RUN: begin
          if (roll && oneshot) begin
            state_q <= ST_HALT;
            done_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (clear) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // done mirrors the HALT state once out of reset.
  a_done_halt: assert property (@(posedge clk) disable iff (rst)
    done_q == (state_q == ST_HALT));

  // Phase never moves while halted unless cleared.
  a_halt_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_HALT && !clear) |=> $stable(cnt_q));

  assign cnt_out   = cnt_q;
  assign gray_out  = cnt_q ^ (cnt_q >> 1);
  assign rollover  = roll;
  assign epoch     = epoch_q;
  assign epoch_sat = epoch_sat_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tlut_sweep_cnt.sv
// Self-checking bench for tlut_sweep_cnt: directed scenarios plus random
// stimulus, all compared against a behavioural sweep model.
module tb_tlut_sweep_cnt;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned EPOCH_W = 4;
  localparam int          PHASES  = 256;
  localparam int          EP_TOP  = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               clear;
  logic               oneshot;
  logic [WIDTH-1:0]   mod_max;
  logic [WIDTH-1:0]   cnt_out;
  logic [WIDTH-1:0]   gray_out;
  logic               rollover;
  logic [EPOCH_W-1:0] epoch;
  logic               epoch_sat;
  logic               done;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_cnt;
  int m_epoch;
  bit m_halt;
  bit m_valid = 1'b0;

  // Values sampled during the most recent step
  int obs_cnt;
  int obs_gray;
  int obs_epoch;
  bit obs_roll;
  bit obs_done;
  bit obs_sat;

  tlut_sweep_cnt #(.WIDTH(WIDTH), .EPOCH_W(EPOCH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .oneshot  (oneshot),
    .mod_max  (mod_max),
    .cnt_out  (cnt_out),
    .gray_out (gray_out),
    .rollover (rollover),
    .epoch    (epoch),
    .epoch_sat(epoch_sat),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input bit r, input bit c, input bit e, input bit o, input int m);
    bit exp_roll;
    @(negedge clk);
    rst = r; clear = c; enable = e; oneshot = o; mod_max = WIDTH'(m);
    #1;
    obs_cnt   = int'(cnt_out);
    obs_gray  = int'(gray_out);
    obs_epoch = int'(epoch);
    obs_roll  = rollover;
    obs_done  = done;
    obs_sat   = epoch_sat;
    exp_roll  = !m_halt && e && !c && (m_cnt >= m);
    if (m_valid) begin
      check("cnt",   32'(cnt_out),   32'(m_cnt));
      check("gray",  32'(gray_out),  32'(m_cnt ^ (m_cnt / 2)));
      check("roll",  32'(rollover),  32'(exp_roll));
      check("epoch", 32'(epoch),     32'(m_epoch));
      check("sat",   32'(epoch_sat), 32'(m_epoch == EP_TOP));
      check("done",  32'(done),      32'(m_halt));
    end
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_epoch = 0; m_halt = 1'b0; m_valid = 1'b1;
    end else if (c) begin
      m_cnt = 0; m_epoch = 0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (exp_roll) begin
        m_cnt = 0;
        if (m_epoch < EP_TOP) m_epoch++;
        if (o) m_halt = 1'b1;
      end else if (e) begin
        m_cnt = (m_cnt + 1) % PHASES;
      end
    end
  endtask

  initial begin
    int pc;
    int mm;
    bit ee;
    bit rr;
    bit cc;
    bit oo;
    rst = 1'b1; clear = 1'b0; enable = 1'b0; oneshot = 1'b0; mod_max = '0;

    // Reset
    step(1, 0, 1, 0, 5);
    step(1, 0, 0, 0, 5);
    step(0, 0, 0, 0, 5);
    check("rst_cnt", 32'(obs_cnt), 32'd0);
    check("rst_done", 32'(obs_done), 32'd0);

    // Free-run, mod_max=5
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0, 5);
      check("fr_roll", 32'(obs_roll), 32'(i == 5 || i == 11 || i == 17));
      if (i == 5) check("fr_gray5", 32'(obs_gray), 32'h07);
    end
    step(0, 0, 0, 0, 5);
    check("fr_epoch", 32'(obs_epoch), 32'd3);

    // Gated enable, mod_max=3
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 16; i++) begin
      ee = (i % 2 == 0);
      pc = m_cnt;
      step(0, 0, ee, 0, 3);
      check("gt_roll", 32'(obs_roll), 32'(pc == 3 && ee));
    end

    // One-shot, mod_max=2; oneshot dropped while halted
    step(0, 1, 0, 0, 2);
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1, (i < 8), 2);
      check("os_roll", 32'(obs_roll), 32'(i == 2));
      check("os_done", 32'(obs_done), 32'(i >= 3));
      if (i >= 3) begin
        check("os_cnt", 32'(obs_cnt), 32'd0);
        check("os_epoch", 32'(obs_epoch), 32'd1);
      end
    end
    step(0, 1, 1, 1, 2);
    step(0, 0, 1, 0, 2);
    check("os_clr_done", 32'(obs_done), 32'd0);
    check("os_clr_cnt", 32'(obs_cnt), 32'd0);
    step(0, 0, 1, 0, 2);
    check("os_resume", 32'(obs_cnt), 32'd1);

    // Modulus shrink 200 -> 10 at cnt=100
    step(0, 1, 0, 0, 200);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 200);
    step(0, 0, 1, 0, 10);
    check("sh_cnt", 32'(obs_cnt), 32'd100);
    check("sh_roll", 32'(obs_roll), 32'd1);
    step(0, 0, 1, 0, 10);
    check("sh_wrap", 32'(obs_cnt), 32'd0);
    for (int j = 1; j <= 10; j++) begin
      step(0, 0, 1, 0, 10);
      check("sh_sweep", 32'(obs_roll), 32'(j == 10));
    end

    // Epoch saturation with mod_max=0
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0, 0);
      check("sat_cnt", 32'(obs_cnt), 32'd0);
      check("sat_epoch", 32'(obs_epoch), 32'((i < EP_TOP) ? i : EP_TOP));
    end
    step(0, 0, 0, 0, 0);
    check("sat_hold", 32'(obs_epoch), 32'd15);
    check("sat_flag", 32'(obs_sat), 32'd1);

    // Priority: clear beats rollover, rst beats everything
    step(0, 1, 0, 0, 5);
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 5);
    step(0, 1, 1, 0, 5);
    check("pr_clr_cnt", 32'(obs_cnt), 32'd5);
    check("pr_clr_roll", 32'(obs_roll), 32'd0);
    check("pr_clr_ep", 32'(obs_epoch), 32'd1);
    step(0, 0, 0, 0, 20);
    check("pr_clr_next", 32'(obs_cnt), 32'd0);
    check("pr_clr_epn", 32'(obs_epoch), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 20);
    step(1, 0, 1, 1, 20);
    check("pr_rst_cnt", 32'(obs_cnt), 32'd7);
    step(0, 0, 0, 0, 20);
    check("pr_rst_next", 32'(obs_cnt), 32'd0);
    check("pr_rst_gray", 32'(obs_gray), 32'd0);

    // Randomized stimulus against the model
    mm = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        mm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      rr = ($urandom_range(0, 199) == 0);
      cc = ($urandom_range(0, 39) == 0);
      ee = ($urandom_range(0, 3) != 0);
      oo = ($urandom_range(0, 7) == 0);
      step(rr, cc, ee, oo, mm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlut_sweep_cnt.md
# tlut_sweep_cnt

Parametrised sweep counter for the temporal-LUT multiplier datapath. It generates the per-cycle LUT address phase and a terminal rollover pulse. Over the plain rollover counter it adds:
- a programmable modulus;
- synchronous clear;
- a Gray-coded phase output;
- a saturating epoch count of completed sweeps;
- a one-shot mode that halts after a single sweep.

It sits between the multiplier control FSM and the LUT address/compare logic.

## Interface
- WIDTH, 8: phase counter width; matches the multiplier input operand width.
- EPOCH_W, 4: width of the completed-sweep (epoch) counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  advance the phase by one this cycle.
- clear  in  1  synchronous clear of phase, epoch and halt state.
- oneshot  in  1  1 = halt after the next rollover; 0 = free-running wrap.
- mod_max  in  WIDTH  terminal phase value; the sweep is 0..mod_max inclusive.
- cnt_out  out  WIDTH  current phase, binary.
- gray_out  out  WIDTH  current phase, Gray-coded: cnt_out ^ (cnt_out >> 1).
- rollover  out  1  combinational; high in the cycle the phase leaves its terminal value.
- epoch  out  EPOCH_W  number of completed sweeps, saturating.
- epoch_sat  out  1  epoch == 2^EPOCH_W-1.
- done  out  1  one-shot sweep finished; block halted.

## Operation
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: cnt_out=0, gray_out=0, rollover=0, epoch=0, epoch_sat=0, done=0, state=RUN.
- Priority of control inputs: rst > clear > enable.
- State machine, two states: RUN and HALT.
  - RUN -> HALT on a qualified rollover when oneshot=1.
  - HALT -> RUN only on clear or rst.
- Terminal condition: term = (cnt >= mod_max). The ">=" is deliberate. If mod_max is lowered below the current phase, the next enabled cycle wraps instead of running through 2^WIDTH.
- rollover = enable & term & ~clear & (state==RUN), purely combinational.
- Phase update in RUN:
  - clear: cnt <- 0.
  - else if rollover: cnt <- 0.
  - else if enable: cnt <- cnt + 1, modulo 2^WIDTH.
  - else: hold.
- Epoch update:
  - clear: epoch <- 0.
  - on rollover: epoch <- epoch + 1 unless already all-ones; it holds at all-ones, with no wrap.
- One-shot: a rollover with oneshot=1 sets done=1 and moves to HALT on the next edge, with cnt=0.
  - In HALT, enable is ignored, rollover=0 and cnt/epoch hold.
  - Deasserting oneshot while in HALT does not resume counting.
- mod_max=0: every enabled RUN cycle is a rollover; cnt stays 0 and epoch advances each enabled cycle.
- mod_max=all-ones gives the full 2^WIDTH sweep.
- Changing mod_max takes effect in the same cycle, since term is combinational.
- gray_out is a combinational function of the cnt register only, so it carries no glitch-relevant logic beyond that XOR.

## Timing
- cnt_out, epoch, epoch_sat and done are registered and update on the clk edge after the triggering inputs.
- rollover is valid in the same cycle cnt_out == mod_max with enable high. In the following cycle cnt_out=0.
- Full sweep length with enable held high: mod_max+1 cycles between rollover pulses.
- clear is applied in a single cycle. Outputs read zero/RUN values on the next cycle. rollover is forced low in the clear cycle itself.
- rst asserted mid-sweep gives the reset values on the next cycle, regardless of enable, clear or state.
- There is no other latency; the block has no handshake beyond enable.

## Test plan
- Free-run: WIDTH=8, mod_max=5, oneshot=0, enable=1 for 20 cycles.
  - cnt_out runs 0..5 repeating; rollover pulses at cycles 5, 11 and 17; epoch=3.
  - gray_out=0x07 when cnt_out=5.
- Gated enable: mod_max=3, enable toggling 1,0,1,0…
  - cnt advances only on enabled cycles.
  - rollover is high only when cnt=3 and enable=1, never when cnt=3 and enable=0.
- One-shot: oneshot=1, mod_max=2, enable=1.
  - rollover in cycle 2; done=1 and cnt=0 from cycle 3.
  - With enable still high for 10 more cycles, cnt stays 0, epoch stays 1 and rollover stays 0.
  - After clear: done=0 and counting resumes.
- Modulus shrink: mod_max=200, run to cnt=100, then set mod_max=10.
  - rollover is asserted in that same cycle; next cnt=0; the following sweep is 0..10.
- Saturation and boundaries: EPOCH_W=4, mod_max=0, enable=1 for 20 cycles.
  - epoch reaches 15 after 15 cycles and holds at 15; epoch_sat=1.
  - cnt stays 0 throughout.
- Priority: assert clear and enable together at cnt=mod_max, then assert rst mid-sweep at cnt=7.
  - clear case: rollover=0 that cycle and epoch does not increment; outputs are zero next cycle.
  - rst case: all outputs are at reset values next cycle.
